// File: rtl/vic_nested.sv
// Nested vectored interrupt controller: edge-latched requests, 2-bit priority
// arbitration, hardware return stack and fetch/condition-code redirect.
module vic_nested #(
  parameter int          NUM_SRC    = 31,
  parameter int          NEST_DEPTH = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          SETTLE_CYC = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] i_ext,
  input  logic [31:0]        i_PC,
  input  logic [3:0]         i_CCodes,
  input  logic               i_reti,
  input  logic               i_NOT_FLUSH,
  input  logic               i_stall,
  input  logic               i_VIC_we,
  input  logic [2:0]         i_VIC_regaddr,
  input  logic [31:0]        i_VIC_data,
  output logic [31:0]        o_VIC_data,
  output logic [31:0]        o_VIC_iaddr,
  output logic               o_VIC_ctrl,
  output logic [3:0]         o_CCodes,
  output logic               o_VIC_CCodes_ctrl
);

  localparam logic [31:0] SRC_MASK =
    (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                    : ((32'd1 << NUM_SRC) - 32'd1);
  localparam logic [3:0] DMAX = 4'(NEST_DEPTH);
  localparam logic [2:0] SET_LAST = 3'(SETTLE_CYC - 1);
  localparam logic [2:0] LVL_IDLE = 3'd7;

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] enable, pending, prio_lo, prio_hi;
  logic [31:0] ext_w, ext_q, rise, clr, pend_n;
  logic [63:0] prio_all;
  logic [3:0]  depth;
  logic [2:0]  level;
  logic        uf;
  logic        full;
  logic        go;

  logic [31:0] stk_pc  [8];
  logic [3:0]  stk_cc  [8];
  logic [2:0]  stk_lvl [8];
  logic [2:0]  push_idx, top_idx;

  logic [31:0] cand;
  logic        found;
  logic [4:0]  win_idx;
  logic [1:0]  win_prio;
  logic [31:0] win_oh;

  logic do_take, do_reti, do_uf;
  logic wr_pend, wr_stat;

  always_comb begin
    ext_w = '0;
    for (int i = 0; i < NUM_SRC; i++) ext_w[i] = i_ext[i];
  end

  assign rise     = ext_w & ~ext_q;
  assign prio_all = {prio_hi, prio_lo};
  assign full     = (depth == DMAX);
  assign go       = i_NOT_FLUSH & ~i_stall;
  assign push_idx = depth[2:0];
  assign top_idx  = depth[2:0] - 3'd1;
  assign wr_pend  = i_VIC_we & (i_VIC_regaddr == 3'd1);
  assign wr_stat  = i_VIC_we & (i_VIC_regaddr == 3'd4);

  // Highest priority wins; strict > keeps the lowest index on ties.
  always_comb begin
    cand     = '0;
    found    = 1'b0;
    win_idx  = '0;
    win_prio = '0;
    for (int i = 0; i < 32; i++) begin
      cand[i] = pending[i] & enable[i] &
                ((level == LVL_IDLE) ||
                 ({1'b0, prio_all[2*i +: 2]} > level));
      if (cand[i] && (!found || prio_all[2*i +: 2] > win_prio)) begin
        found    = 1'b1;
        win_idx  = 5'(i);
        win_prio = prio_all[2*i +: 2];
      end
    end
  end

  always_comb begin
    win_oh = '0;
    win_oh[win_idx] = 1'b1;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    do_take = 1'b0;
    do_reti = 1'b0;
    do_uf   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_reti & go) begin
          if (depth != 4'd0) do_reti = 1'b1;
          else               do_uf   = 1'b1;
        end else if (found & go & ~full) begin
          do_take = 1'b1;
        end
        if (do_take | do_reti) begin
          state_n = SETTLE;
          cnt_n   = 3'd0;
        end
      end
      SETTLE: begin
        if (cnt == SET_LAST) state_n = IDLE;
        else                 cnt_n   = cnt + 3'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // A fresh edge always beats a clear landing in the same cycle.
  always_comb begin
    clr = '0;
    if (wr_pend) clr = clr | i_VIC_data;
    if (do_take) clr = clr | win_oh;
    pend_n = ((pending & ~clr) | rise) & SRC_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      enable            <= '0;
      pending           <= '0;
      prio_lo           <= '0;
      prio_hi           <= '0;
      ext_q             <= '0;
      depth             <= '0;
      level             <= LVL_IDLE;
      uf                <= 1'b0;
      o_VIC_iaddr       <= '0;
      o_VIC_ctrl        <= 1'b0;
      o_CCodes          <= '0;
      o_VIC_CCodes_ctrl <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      ext_q             <= ext_w;
      pending           <= pend_n;
      o_VIC_ctrl        <= do_take | do_reti;
      o_VIC_CCodes_ctrl <= do_reti;
      if (i_VIC_we) begin
        unique case (1'b1)
          i_VIC_regaddr == 3'd0: enable  <= i_VIC_data & SRC_MASK;
          i_VIC_regaddr == 3'd2: prio_lo <= i_VIC_data;
          i_VIC_regaddr == 3'd3: prio_hi <= i_VIC_data;
          default: ;
        endcase
      end
      if (do_uf)        uf <= 1'b1;
      else if (wr_stat) uf <= 1'b0;
      if (do_take) begin
        o_VIC_iaddr <= VEC_BASE + {25'd0, win_idx, 2'b00};
        depth       <= depth + 4'd1;
        level       <= {1'b0, win_prio};
      end
      if (do_reti) begin
        o_VIC_iaddr <= stk_pc[top_idx];
        o_CCodes    <= stk_cc[top_idx];
        level       <= stk_lvl[top_idx];
        depth       <= depth - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_take && !rst) begin
      stk_pc[push_idx]  <= i_PC;
      stk_cc[push_idx]  <= i_CCodes;
      stk_lvl[push_idx] <= level;
    end
  end

  always_comb begin
    o_VIC_data = '0;
    unique case (1'b1)
      i_VIC_regaddr == 3'd0: o_VIC_data = enable;
      i_VIC_regaddr == 3'd1: o_VIC_data = pending;
      i_VIC_regaddr == 3'd2: o_VIC_data = prio_lo;
      i_VIC_regaddr == 3'd3: o_VIC_data = prio_hi;
      i_VIC_regaddr == 3'd4:
        o_VIC_data = {22'd0, full, uf, 1'b0, level, depth};
      default: o_VIC_data = '0;
    endcase
  end

endmodule

// File: tb/tb_vic_nested.sv
// Directed bench for vic_nested (NEST_DEPTH=2, SETTLE_CYC=3).
module tb_vic_nested;

  logic        clk = 1'b0;
  logic        rst;
  logic [30:0] ext;
  logic [31:0] pc;
  logic [3:0]  cc;
  logic        reti, nflush, stall, we;
  logic [2:0]  regaddr;
  logic [31:0] wdata;
  logic [31:0] rdata, iaddr;
  logic        ctrl, cc_ctrl;
  logic [3:0]  cc_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] r;

  vic_nested #(
    .NUM_SRC(31), .NEST_DEPTH(2),
    .VEC_BASE(32'h0000_0100), .SETTLE_CYC(3)
  ) dut (
    .clk(clk), .rst(rst), .i_ext(ext), .i_PC(pc), .i_CCodes(cc),
    .i_reti(reti), .i_NOT_FLUSH(nflush), .i_stall(stall),
    .i_VIC_we(we), .i_VIC_regaddr(regaddr), .i_VIC_data(wdata),
    .o_VIC_data(rdata), .o_VIC_iaddr(iaddr), .o_VIC_ctrl(ctrl),
    .o_CCodes(cc_out), .o_VIC_CCodes_ctrl(cc_ctrl)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1; regaddr = a; wdata = d;
    tick(1);
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    regaddr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick(2); rst = 1'b0;
    checks++;
    if ({iaddr, ctrl, cc_out, cc_ctrl} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outs got %h want 0", {iaddr, ctrl, cc_out, cc_ctrl});
    end
    rd(3'd4, r); checks++;
    if (r !== 32'h70) begin errors++; $display("FAIL reset_status got %h want 70", r); end
    rd(3'd0, r); checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_enable got %h want 0", r); end
  endtask

  task automatic test_basic_take;
    wr(3'd0, 32'h1); wr(3'd2, 32'h0);
    pc = 32'h40; cc = 4'b1010;
    ext[0] = 1'b1; tick(1);
    checks++;
    if (ctrl !== 1'b0) begin errors++; $display("FAIL take_early ctrl got %b want 0", ctrl); end
    rd(3'd1, r); checks++;
    if (r !== 32'h1) begin errors++; $display("FAIL take_pend_set got %h want 1", r); end
    tick(1); ext[0] = 1'b0;
    checks++;
    if (ctrl !== 1'b1 || iaddr !== 32'h100) begin
      errors++; $display("FAIL take_redirect ctrl %b iaddr %h want 1 100", ctrl, iaddr);
    end
    rd(3'd4, r); checks++;
    if (r !== 32'h001) begin errors++; $display("FAIL take_status got %h want 001", r); end
    rd(3'd1, r); checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL take_pend_clr got %h want 0", r); end
    tick(1); checks++;
    if (ctrl !== 1'b0 || iaddr !== 32'h100) begin
      errors++; $display("FAIL take_pulse_len ctrl %b iaddr %h want 0 100", ctrl, iaddr);
    end
    tick(2);
    reti = 1'b1; tick(1); reti = 1'b0;
    checks++;
    if (ctrl !== 1'b1 || cc_ctrl !== 1'b1 || iaddr !== 32'h40 || cc_out !== 4'b1010) begin
      errors++;
      $display("FAIL basic_reti ctrl %b ccc %b iaddr %h cc %b want 1 1 40 1010",
               ctrl, cc_ctrl, iaddr, cc_out);
    end
    rd(3'd4, r); checks++;
    if (r !== 32'h070) begin errors++; $display("FAIL basic_reti_status got %h want 070", r); end
    tick(3);
  endtask

  task automatic test_nesting;
    wr(3'd0, 32'h28); wr(3'd2, 32'h0C40);
    pc = 32'h80; cc = 4'b0011;
    ext[3] = 1'b1; tick(2); ext[3] = 1'b0;
    checks++;
    if (ctrl !== 1'b1 || iaddr !== 32'h10C) begin
      errors++; $display("FAIL nest_first ctrl %b iaddr %h want 1 10c", ctrl, iaddr);
    end
    tick(3);
    pc = 32'h200; cc = 4'b0101;
    ext[5] = 1'b1; tick(2); ext[5] = 1'b0;
    checks++;
    if (ctrl !== 1'b1 || iaddr !== 32'h114) begin
      errors++; $display("FAIL nest_preempt ctrl %b iaddr %h want 1 114", ctrl, iaddr);
    end
    rd(3'd4, r); checks++;
    if (r !== 32'h232) begin errors++; $display("FAIL nest_status got %h want 232", r); end
    tick(3);
    reti = 1'b1; tick(1); reti = 1'b0;
    checks++;
    if (ctrl !== 1'b1 || cc_ctrl !== 1'b1 || iaddr !== 32'h200 || cc_out !== 4'b0101) begin
      errors++;
      $display("FAIL nest_reti1 ctrl %b ccc %b iaddr %h cc %b want 1 1 200 0101",
               ctrl, cc_ctrl, iaddr, cc_out);
    end
    rd(3'd4, r); checks++;
    if (r !== 32'h011) begin errors++; $display("FAIL nest_reti1_status got %h want 011", r); end
    tick(3);
    reti = 1'b1; tick(1); reti = 1'b0;
    checks++;
    if (iaddr !== 32'h80 || cc_out !== 4'b0011 || cc_ctrl !== 1'b1) begin
      errors++; $display("FAIL nest_reti2 iaddr %h cc %b ccc %b want 80 0011 1", iaddr, cc_out, cc_ctrl);
    end
    tick(3);
  endtask

  task automatic test_tie_break;
    wr(3'd0, 32'h84); wr(3'd2, 32'h8020);
    pc = 32'h300; cc = 4'b1100;
    ext[2] = 1'b1; ext[7] = 1'b1; tick(2); ext[2] = 1'b0; ext[7] = 1'b0;
    checks++;
    if (ctrl !== 1'b1 || iaddr !== 32'h108) begin
      errors++; $display("FAIL tie_first ctrl %b iaddr %h want 1 108", ctrl, iaddr);
    end
    tick(4); checks++;
    if (ctrl !== 1'b0) begin errors++; $display("FAIL tie_no_preempt ctrl %b want 0", ctrl); end
    rd(3'd1, r); checks++;
    if (r !== 32'h80) begin errors++; $display("FAIL tie_pend got %h want 80", r); end
    reti = 1'b1; tick(1); reti = 1'b0;
    checks++;
    if (ctrl !== 1'b1 || iaddr !== 32'h300) begin
      errors++; $display("FAIL tie_reti ctrl %b iaddr %h want 1 300", ctrl, iaddr);
    end
    tick(3); checks++;
    if (ctrl !== 1'b0) begin errors++; $display("FAIL tie_settle ctrl %b want 0", ctrl); end
    tick(1); checks++;
    if (ctrl !== 1'b1 || iaddr !== 32'h11C) begin
      errors++; $display("FAIL tie_second ctrl %b iaddr %h want 1 11c", ctrl, iaddr);
    end
    tick(3);
    reti = 1'b1; tick(1); reti = 1'b0;
    tick(3);
  endtask

  task automatic test_stack_full;
    wr(3'd0, 32'h52); wr(3'd2, 32'h3204);
    pc = 32'h400; cc = 4'b0001;
    ext[1] = 1'b1; tick(2); ext[1] = 1'b0;
    checks++;
    if (iaddr !== 32'h104) begin errors++; $display("FAIL full_t1 iaddr %h want 104", iaddr); end
    tick(3);
    ext[4] = 1'b1; tick(2); ext[4] = 1'b0;
    checks++;
    if (iaddr !== 32'h110) begin errors++; $display("FAIL full_t2 iaddr %h want 110", iaddr); end
    tick(3);
    ext[6] = 1'b1; tick(2); ext[6] = 1'b0;
    checks++;
    if (ctrl !== 1'b0) begin errors++; $display("FAIL full_no_take ctrl %b want 0", ctrl); end
    tick(2);
    rd(3'd4, r); checks++;
    if (r !== 32'h222) begin errors++; $display("FAIL full_status got %h want 222", r); end
    rd(3'd1, r); checks++;
    if (r !== 32'h40) begin errors++; $display("FAIL full_pend_held got %h want 40", r); end
    wr(3'd1, 32'h40);
    rd(3'd1, r); checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL w1c_clear got %h want 0", r); end
    reti = 1'b1; tick(1); reti = 1'b0; tick(3);
    reti = 1'b1; tick(1); reti = 1'b0; tick(3);
    reti = 1'b1; tick(1); reti = 1'b0;
    checks++;
    if (ctrl !== 1'b0 || cc_ctrl !== 1'b0) begin
      errors++; $display("FAIL underflow_pulse ctrl %b ccc %b want 0 0", ctrl, cc_ctrl);
    end
    rd(3'd4, r); checks++;
    if (r !== 32'h170) begin errors++; $display("FAIL underflow_status got %h want 170", r); end
    wr(3'd4, 32'h0);
    rd(3'd4, r); checks++;
    if (r !== 32'h070) begin errors++; $display("FAIL underflow_clear got %h want 070", r); end
  endtask

  task automatic test_gating;
    wr(3'd0, 32'h2);
    pc = 32'h500;
    stall = 1'b1;
    ext[1] = 1'b1; tick(1); ext[1] = 1'b0;
    tick(2); checks++;
    if (ctrl !== 1'b0) begin errors++; $display("FAIL gate_stall ctrl %b want 0", ctrl); end
    stall = 1'b0; nflush = 1'b0;
    tick(1); checks++;
    if (ctrl !== 1'b0) begin errors++; $display("FAIL gate_flush ctrl %b want 0", ctrl); end
    nflush = 1'b1;
    tick(1); checks++;
    if (ctrl !== 1'b1 || iaddr !== 32'h104) begin
      errors++; $display("FAIL gate_release ctrl %b iaddr %h want 1 104", ctrl, iaddr);
    end
    reti = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1); checks++;
      if (ctrl !== 1'b0 || cc_ctrl !== 1'b0) begin
        errors++; $display("FAIL settle_reti_%0d ctrl %b ccc %b want 0 0", i, ctrl, cc_ctrl);
      end
    end
    reti = 1'b0;
    rd(3'd4, r); checks++;
    if (r !== 32'h011) begin errors++; $display("FAIL settle_depth got %h want 011", r); end
    reti = 1'b1; tick(1); reti = 1'b0;
    checks++;
    if (ctrl !== 1'b1 || iaddr !== 32'h500) begin
      errors++; $display("FAIL gate_reti ctrl %b iaddr %h want 1 500", ctrl, iaddr);
    end
    tick(3);
  endtask

  task automatic test_reset_w1c;
    wr(3'd0, 32'h12);
    ext[1] = 1'b1; tick(2); ext[1] = 1'b0;
    tick(3);
    ext[4] = 1'b1; tick(2); ext[4] = 1'b0;
    checks++;
    if (ctrl !== 1'b1 || iaddr !== 32'h110) begin
      errors++; $display("FAIL rst_setup ctrl %b iaddr %h want 1 110", ctrl, iaddr);
    end
    tick(1);
    rst = 1'b1; tick(1); rst = 1'b0;
    checks++;
    if ({iaddr, ctrl, cc_out, cc_ctrl} !== 38'd0) begin
      errors++; $display("FAIL midrst_outs got %h want 0", {iaddr, ctrl, cc_out, cc_ctrl});
    end
    rd(3'd4, r); checks++;
    if (r !== 32'h070) begin errors++; $display("FAIL midrst_status got %h want 070", r); end
    ext[3] = 1'b1; tick(1); ext[3] = 1'b0; tick(1);
    ext[3] = 1'b1;
    wr(3'd1, 32'h8);
    ext[3] = 1'b0;
    rd(3'd1, r); checks++;
    if (r !== 32'h8) begin errors++; $display("FAIL w1c_edge got %h want 8", r); end
  endtask

  initial begin
    rst = 1'b1; ext = '0; pc = '0; cc = '0; reti = 1'b0;
    nflush = 1'b1; stall = 1'b0; we = 1'b0; regaddr = '0; wdata = '0;
    #1;
    test_reset;
    test_basic_take;
    test_nesting;
    test_tie_break;
    test_stack_full;
    test_gating;
    test_reset_w1c;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
